uart_tx_fifo_reader: RTL and testbench

//   UART transmitter that drains the TX-side FIFO. Serializes bytes on o_tx
//   as start / data (LSB first) / [parity] / stop. Pops one word per frame

---
 rtl/uart_tx_fifo_reader_pkg.sv | 21 ++
 rtl/uart_tx_fifo_reader.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared definitions for the UART TX FIFO reader: FSM state encoding and default frame parameters.
// The receiver side imports the same package so both ends agree on encodings.
package uart_tx_fifo_reader_pkg;

  localparam int DEF_NB_DATA    = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops one word per frame from a show-ahead FIFO and serializes it.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop period.
module uart_tx_fifo_reader
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_empty,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_rd,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int TICK_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int BIT_W  = $clog2(NB_DATA) + 1;
  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NB_DATA - 1);

  state_t              state, state_next;
  logic [TICK_W-1:0]   tick_cnt, tick_next;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic [NB_DATA-1:0]  shreg, shreg_next;
  logic                tx_reg, tx_next;
  logic                busy_reg;
  logic                done_reg, done_next;
  logic                load;
`ifdef UART_TX_PARITY_EN
  logic                par_reg, par_next;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      tx_reg   <= tx_next;
      busy_reg <= (state_next != ST_IDLE);
      done_reg <= done_next;
`ifdef UART_TX_PARITY_EN
      par_reg  <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    done_next  = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_empty) begin
          load       = 1'b1;
          shreg_next = i_data;
          tick_next  = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = ST_DATA;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_next  = '0;
            shreg_next = shreg >> 1;
            bit_next   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_next  = '0;
            state_next = ST_STOP;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_tick) begin
          if (tick_cnt == SB_LAST) begin
            tick_next  = '0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the word as popped, since shreg is shifted away during DATA.
  assign par_next = load ? ^i_data : par_reg;
`endif

  // The line value is registered from the next state so o_tx changes on the same edge as state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  assign o_rd      = load & i_reset;
  assign o_tx      = tx_reg;
  assign o_busy    = busy_reg;
  assign o_tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench for uart_tx_fifo_reader: default DUT plus a two-stop-bit (SB_TICK=32) instance.
// A tick-counting line decoder and FIFO queues form the reference; build with UART_TX_PARITY_EN to cover parity.
module tb_uart_tx_fifo_reader;

  localparam int NB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOTS = NB + 2;
`else
  localparam int NSLOTS = NB + 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  logic       clock, reset_n, tick;
  logic       empty_a, empty_b;
  logic [7:0] data_a, data_b;
  logic       rd_a, tx_a, busy_a, done_a;
  logic       rd_b, tx_b, busy_b, done_b;
  bit         sel;
  logic       tx_m, busy_m, done_m;
  int         total, bad;
  int         rd_cnt_a, rd_cnt_b, rd_bad_a, rd_bad_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       rd_lat_a, rd_lat_b;
  int         tick_div;

  uart_tx_fifo_reader dut_a (
    .i_clock(clock), .i_reset(reset_n), .i_tick(tick), .i_empty(empty_a), .i_data(data_a),
    .o_rd(rd_a), .o_tx(tx_a), .o_busy(busy_a), .o_tx_done(done_a)
  );

  uart_tx_fifo_reader #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32)) dut_b (
    .i_clock(clock), .i_reset(reset_n), .i_tick(tick), .i_empty(empty_b), .i_data(data_b),
    .o_rd(rd_b), .o_tx(tx_b), .o_busy(busy_b), .o_tx_done(done_b)
  );

  assign tx_m   = sel ? tx_b   : tx_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One tick every 4 clocks, driven mid-cycle so it is stable at both edges.
  initial begin
    tick = 1'b0;
    tick_div = 0;
    forever begin
      @(posedge clock);
      #2;
      tick_div = (tick_div + 1) % 4;
      tick = (tick_div == 0);
    end
  end

  // Show-ahead FIFO models: a pop seen in one cycle removes the head at the next negedge.
  initial begin
    empty_a = 1'b1; data_a = 8'h00; rd_lat_a = 1'b0;
    forever begin
      @(negedge clock);
      if (rd_lat_a && q_a.size() > 0) void'(q_a.pop_front());
      empty_a = (q_a.size() == 0);
      data_a  = empty_a ? 8'h00 : q_a[0];
      #1;
      rd_lat_a = rd_a;
      if (rd_a) rd_cnt_a++;
      if (rd_a && empty_a) rd_bad_a++;
    end
  end

  initial begin
    empty_b = 1'b1; data_b = 8'h00; rd_lat_b = 1'b0;
    forever begin
      @(negedge clock);
      if (rd_lat_b && q_b.size() > 0) void'(q_b.pop_front());
      empty_b = (q_b.size() == 0);
      data_b  = empty_b ? 8'h00 : q_b[0];
      #1;
      rd_lat_b = rd_b;
      if (rd_b) rd_cnt_b++;
      if (rd_b && empty_b) rd_bad_b++;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit to_b, input logic [7:0] b);
    if (to_b) q_b.push_back(b);
    else q_a.push_back(b);
  endtask

  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // Decodes one frame off the selected line by counting ticks per slot; called at a negedge.
  task automatic capture_frame(input int stop_ticks, input int budget,
                               output logic [7:0] data, output logic par, output int data_clks);
    int waited, cnt, clks, glitches, early_done, busy_low;
    logic v;
    logic [NSLOTS-1:0] bits;
    data = 8'h00; par = 1'b0; data_clks = 0;
    waited = 0; glitches = 0; early_done = 0; busy_low = 0; bits = '0;
    while (tx_m !== 1'b0 && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    check_output("start_seen", {31'd0, tx_m}, 32'd0);
    if (tx_m !== 1'b0) return;
    for (int s = 0; s <= NSLOTS; s++) begin
      v = tx_m; cnt = 0; clks = 0;
      forever begin
        clks++;
        if (tx_m !== v) glitches++;
        if (done_m) early_done++;
        if (!busy_m) busy_low++;
        if (tick) cnt++;
        if (cnt == ((s == NSLOTS) ? stop_ticks : 16)) break;
        @(negedge clock);
      end
      if (s < NSLOTS) bits[s] = v;
      else check_output("stop_bit", {31'd0, v}, 32'd1);
      if (s == 1) data_clks = clks;
      @(negedge clock);
    end
    check_output("start_bit", {31'd0, bits[0]}, 32'd0);
    check_output("bit_glitches", glitches, 0);
    check_output("early_done", early_done, 0);
    check_output("busy_in_frame", busy_low, 0);
    check_output("done_pulse", {31'd0, done_m}, 32'd1);
    check_output("busy_dropped", {31'd0, busy_m}, 32'd0);
    for (int i = 0; i < NB; i++) data[i] = bits[1 + i];
`ifdef UART_TX_PARITY_EN
    par = bits[NB + 1];
`endif
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] exp_q[$];
    logic [7:0] d, e;
    logic p;
    int clks, rd0, lows, highs;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0};
    vecs[2] = '{8'h0F, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h07, 1'b1};
    vecs[6] = '{8'h03, 1'b0};
    vecs[7] = '{8'h80, 1'b1};

    total = 0; bad = 0; sel = 1'b0;
    rd_cnt_a = 0; rd_cnt_b = 0; rd_bad_a = 0; rd_bad_b = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset_tx", {31'd0, tx_a}, 32'd1);
    check_output("reset_busy", {31'd0, busy_a}, 32'd0);
    check_output("reset_done", {31'd0, done_a}, 32'd0);
    check_output("reset_rd", {31'd0, rd_a}, 32'd0);
    #2 reset_n = 1'b1;

    // Empty FIFO: the line must stay idle.
    lows = 0; highs = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) highs++;
    end
    check_output("idle_tx_low", lows, 0);
    check_output("idle_busy_done", highs, 0);
    check_output("idle_rd_count", rd_cnt_a, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      rd0 = rd_cnt_a;
      apply_stimulus(1'b0, vecs[i].data);
      capture_frame(16, 10, d, p, clks);
      check_output("vec_data", {24'd0, d}, {24'd0, vecs[i].data});
      check_output("vec_bit_clks", clks, 64);
      check_output("vec_rd_pulses", rd_cnt_a - rd0, 1);
`ifdef UART_TX_PARITY_EN
      check_output("vec_parity", {31'd0, p}, {31'd0, vecs[i].exp_par});
`endif
      repeat (5) @(negedge clock);
    end

    $display("[TB] back-to-back A3, 0F");
    rd0 = rd_cnt_a;
    apply_stimulus(1'b0, 8'hA3);
    apply_stimulus(1'b0, 8'h0F);
    capture_frame(16, 10, d, p, clks);
    check_output("b2b_first", {24'd0, d}, 32'hA3);
    capture_frame(16, 1, d, p, clks);
    check_output("b2b_second", {24'd0, d}, 32'h0F);
    check_output("b2b_rd_pulses", rd_cnt_a - rd0, 2);
    repeat (5) @(negedge clock);

    $display("[TB] random burst");
    for (int i = 0; i < 6; i++) begin
      e = 8'($urandom_range(0, 255));
      apply_stimulus(1'b0, e);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      capture_frame(16, (i == 0) ? 10 : 1, d, p, clks);
      e = exp_q.pop_front();
      check_output("rand_data", {24'd0, d}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
      check_output("rand_parity", {31'd0, p}, {31'd0, model_parity(e)});
`endif
    end
    repeat (5) @(negedge clock);

    $display("[TB] two stop bits");
    sel = 1'b1;
    rd0 = rd_cnt_b;
    apply_stimulus(1'b1, 8'h3C);
    apply_stimulus(1'b1, 8'hC5);
    capture_frame(32, 10, d, p, clks);
    check_output("sb32_first", {24'd0, d}, 32'h3C);
    capture_frame(32, 1, d, p, clks);
    check_output("sb32_second", {24'd0, d}, 32'hC5);
`ifdef UART_TX_PARITY_EN
    check_output("sb32_parity", {31'd0, p}, {31'd0, model_parity(8'hC5)});
`endif
    check_output("sb32_rd_pulses", rd_cnt_b - rd0, 2);
    sel = 1'b0;
    repeat (5) @(negedge clock);

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b0, 8'hFF);
    lows = 0;
    while (tx_a !== 1'b0 && lows < 10) begin
      @(negedge clock);
      lows++;
    end
    check_output("rst_frame_started", {31'd0, tx_a}, 32'd0);
    repeat (286) @(negedge clock);
    check_output("rst_busy_before", {31'd0, busy_a}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("rst_async_tx", {31'd0, tx_a}, 32'd1);
    check_output("rst_async_busy", {31'd0, busy_a}, 32'd0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    rd0 = rd_cnt_a;
    lows = 0; highs = 0;
    repeat (300) begin
      @(negedge clock);
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) highs++;
    end
    check_output("rst_after_tx", lows, 0);
    check_output("rst_after_busy", highs, 0);
    check_output("rst_after_rd", rd_cnt_a - rd0, 0);

    check_output("rd_while_empty_a", rd_bad_a, 0);
    check_output("rd_while_empty_b", rd_bad_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
